// File: rtl/bpu_pkg.sv
// Shared definitions for the branch prediction unit: control opcodes,
// next-PC select encodings and the saturating counter reset value.
package bpu_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        PCSEL_PRED   = 2'b00,
        PCSEL_TARGET = 2'b01,
        PCSEL_SEQ    = 2'b10
    } pc_sel_e;

    // Weakly-not-taken: the value just below the taken threshold.
    function automatic int unsigned cnt_reset_val(input int unsigned cnt_w);
        return (32'd1 << (cnt_w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// CNT_W-bit up/down counter that saturates at 0 and all-ones; resets to
// weakly-not-taken.
module sat_counter
    import bpu_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_reset_val(CNT_W));

    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= CNT_INIT;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal BHT + direct-mapped BTB predictor with EX-stage resolution and
// redirect. Optional statistics counters are enabled by BPU_STATS_EN.
module branch_predict_unit
    import bpu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_W       = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [6:0]      ex_opcode,
    input  logic            ex_cond,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      pc_sel
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
    localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W     = XLEN - BTB_IDX_W - 2;

    logic [CNT_W-1:0] bht_cnt    [BHT_ENTRIES];
    logic             btb_valid  [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]  btb_target [BTB_ENTRIES];
    logic             btb_jump   [BTB_ENTRIES];

    // ---------------- IF-stage prediction ----------------
    logic [BHT_IDX_W-1:0] if_bht_idx;
    logic [BTB_IDX_W-1:0] if_btb_idx;
    logic [TAG_W-1:0]     if_tag;
    logic                 btb_hit;

    assign if_bht_idx = if_pc[BHT_IDX_W+1:2];
    assign if_btb_idx = if_pc[BTB_IDX_W+1:2];
    assign if_tag     = if_pc[XLEN-1:BTB_IDX_W+2];
    assign btb_hit    = btb_valid[if_btb_idx] && (btb_tag[if_btb_idx] == if_tag);
    assign pred_taken = btb_hit && (btb_jump[if_btb_idx] || bht_cnt[if_bht_idx][CNT_W-1]);
    assign pred_target = pred_taken ? btb_target[if_btb_idx] : if_pc + XLEN'(4);

    // ---------------- EX-stage resolution ----------------
    logic [BHT_IDX_W-1:0] ex_bht_idx;
    logic [BTB_IDX_W-1:0] ex_btb_idx;
    logic                 is_br, is_jump, ctrl_valid, actual_taken, mispredict;
    pc_sel_e              sel;

    assign ex_bht_idx = ex_pc[BHT_IDX_W+1:2];
    assign ex_btb_idx = ex_pc[BTB_IDX_W+1:2];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        is_br        = 1'b0;
        is_jump      = 1'b0;
        ctrl_valid   = 1'b0;
        actual_taken = 1'b0;
        mispredict   = 1'b0;
        sel          = PCSEL_PRED;

        is_br        = (ex_opcode == OP_BRANCH);
        is_jump      = (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR);
        ctrl_valid   = ex_valid && (is_br || is_jump);
        actual_taken = is_jump || (is_br && ex_cond);
        mispredict   = ctrl_valid &&
                       ((actual_taken != ex_pred_taken) ||
                        (actual_taken && (ex_target != ex_pred_target)));
        if (mispredict) begin
            sel = actual_taken ? PCSEL_TARGET : PCSEL_SEQ;
        end
    end

    assign redirect    = mispredict;
    assign pc_sel      = sel;
    assign redirect_pc = actual_taken ? ex_target : ex_pc + XLEN'(4);

    // ---------------- BHT training ----------------
    logic bht_upd;
    assign bht_upd = ctrl_valid && is_br;

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
        logic sel_entry;
        assign sel_entry = bht_upd && (ex_bht_idx == BHT_IDX_W'(i));

        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (sel_entry && actual_taken),
            .dec (sel_entry && !actual_taken),
            .cnt (bht_cnt[i])
        );
    end

    // ---------------- BTB training ----------------
    logic btb_wr;
    assign btb_wr = ctrl_valid && actual_taken;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
            end
        end else if (btb_wr) begin
            btb_valid[ex_btb_idx] <= 1'b1;
        end
    end

    // NOTE: payload RAM is not reset; the valid bits alone qualify every read.
    always_ff @(posedge clk) begin
        if (btb_wr) begin
            btb_tag[ex_btb_idx]    <= ex_pc[XLEN-1:BTB_IDX_W+2];
            btb_target[ex_btb_idx] <= ex_target;
            btb_jump[ex_btb_idx]   <= is_jump;
        end
    end

`ifdef BPU_STATS_EN
    // Saturating event counters for performance monitoring.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (ctrl_valid && (stat_branches != '1)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit; expected values are
// hand-computed for the default parameters (64-entry BHT, 16-entry BTB).
module tb_branch_predict_unit;
    import bpu_pkg::*;

    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [6:0]  ex_opcode;
    logic        ex_cond;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [1:0]  pc_sel;
`ifdef BPU_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk            (clk),
        .rst            (rst),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_pc          (ex_pc),
        .ex_opcode      (ex_opcode),
        .ex_cond        (ex_cond),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .pc_sel         (pc_sel)
`ifdef BPU_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] pc, input logic [6:0] op,
                            input logic c, input logic [31:0] tgt,
                            input logic pt, input logic [31:0] ptgt);
        ex_valid       = v;
        ex_pc          = pc;
        ex_opcode      = op;
        ex_cond        = c;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc,
                              input logic exp_taken, input logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_taken});
        check({tag, "_target"}, pred_target, exp_tgt);
    endtask

    task automatic check_res(input string tag, input logic exp_redir,
                             input logic [1:0] exp_sel, input logic [31:0] exp_pc);
        #1;
        check({tag, "_redirect"}, {31'd0, redirect}, {31'd0, exp_redir});
        check({tag, "_pc_sel"}, {30'd0, pc_sel}, {30'd0, exp_sel});
        if (exp_redir) check({tag, "_redirect_pc"}, redirect_pc, exp_pc);
    endtask

    initial begin
        rst   = 1'b0;
        if_pc = 32'h100;
        drive_ex(1'b0, 32'h0, OP_ALU, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);

        // Reset state and non-control ops
        next_cycle(); rst = 1'b1;
        drive_ex(1'b1, 32'h100, OP_ALU, 1'b1, 32'h180, 1'b0, 32'h104);
        check_pred("reset_pred", 32'h100, 1'b0, 32'h104);
        check_res("alu_op", 1'b0, 2'b00, 32'h0);

        next_cycle();
        drive_ex(1'b0, 32'h200, OP_BRANCH, 1'b1, 32'h180, 1'b0, 32'h204);
        check_res("invalid_br", 1'b0, 2'b00, 32'h0);

        // First taken BR: redirect; same-cycle IF read still sees old state
        next_cycle();
        drive_ex(1'b1, 32'h200, OP_BRANCH, 1'b1, 32'h180, 1'b0, 32'h204);
        check_res("br_first", 1'b1, 2'b01, 32'h180);
        check_pred("br_same_cycle", 32'h200, 1'b0, 32'h204);

        next_cycle();
        drive_ex(1'b0, 32'h0, OP_ALU, 1'b0, 32'h0, 1'b0, 32'h0);
        check_pred("br_learned", 32'h200, 1'b1, 32'h180);

        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive_ex(1'b1, 32'h200, OP_BRANCH, 1'b1, 32'h180, 1'b1, 32'h180);
            check_res("br_taken_again", 1'b0, 2'b00, 32'h0);
        end

        // Counter saturated at 3: two not-taken needed to flip
        next_cycle();
        drive_ex(1'b1, 32'h200, OP_BRANCH, 1'b0, 32'h180, 1'b1, 32'h180);
        check_res("br_nt1", 1'b1, 2'b10, 32'h204);
        check_pred("br_nt1_pred", 32'h200, 1'b1, 32'h180);

        next_cycle();
        drive_ex(1'b1, 32'h200, OP_BRANCH, 1'b0, 32'h180, 1'b1, 32'h180);
        check_res("br_nt2", 1'b1, 2'b10, 32'h204);
        check_pred("br_nt2_pred", 32'h200, 1'b1, 32'h180);

        next_cycle();
        drive_ex(1'b0, 32'h0, OP_ALU, 1'b0, 32'h0, 1'b0, 32'h0);
        check_pred("br_flipped", 32'h200, 1'b0, 32'h204);

        // JAL shares BHT/BTB index 0 with 0x200; counter=1 so is_jump must decide
        next_cycle();
        drive_ex(1'b1, 32'h300, OP_JAL, 1'b0, 32'h400, 1'b0, 32'h304);
        check_res("jal_first", 1'b1, 2'b01, 32'h400);

        next_cycle();
        drive_ex(1'b0, 32'h0, OP_ALU, 1'b0, 32'h0, 1'b0, 32'h0);
        check_pred("jal_pred", 32'h300, 1'b1, 32'h400);

        next_cycle();
        drive_ex(1'b1, 32'h300, OP_JAL, 1'b0, 32'h400, 1'b1, 32'h400);
        check_res("jal_correct", 1'b0, 2'b00, 32'h0);
        check_pred("br_evicted", 32'h200, 1'b0, 32'h204);

        // JALR target change
        next_cycle();
        drive_ex(1'b1, 32'h344, OP_JALR, 1'b0, 32'h500, 1'b0, 32'h348);
        check_res("jalr_first", 1'b1, 2'b01, 32'h500);

        next_cycle();
        drive_ex(1'b0, 32'h0, OP_ALU, 1'b0, 32'h0, 1'b0, 32'h0);
        check_pred("jalr_pred", 32'h344, 1'b1, 32'h500);

        next_cycle();
        drive_ex(1'b1, 32'h344, OP_JALR, 1'b0, 32'h600, 1'b1, 32'h500);
        check_res("jalr_wrong_tgt", 1'b1, 2'b01, 32'h600);

        next_cycle();
        drive_ex(1'b0, 32'h0, OP_ALU, 1'b0, 32'h0, 1'b0, 32'h0);
        check_pred("jalr_retarget", 32'h344, 1'b1, 32'h600);

        next_cycle();
        check_pred("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Reset with a simultaneous taken JALR: combinational outputs still follow
        next_cycle(); rst = 1'b0;
        drive_ex(1'b1, 32'h300, OP_JALR, 1'b0, 32'h700, 1'b0, 32'h304);
        check_res("res_in_reset", 1'b1, 2'b01, 32'h700);
`ifdef BPU_STATS_EN
        check("stat_branches", stat_branches, 32'd10);
        check("stat_mispredicts", stat_mispredicts, 32'd6);
`endif

        next_cycle(); rst = 1'b1;
        drive_ex(1'b0, 32'h0, OP_ALU, 1'b0, 32'h0, 1'b0, 32'h0);
        check_pred("post_rst_jalr", 32'h344, 1'b0, 32'h348);
        check_pred("post_rst_jal", 32'h300, 1'b0, 32'h304);
`ifdef BPU_STATS_EN
        check("stat_branches_rst", stat_branches, 32'd0);
        check("stat_mispredicts_rst", stat_mispredicts, 32'd0);
`endif

        // Counter back to weakly-not-taken: one taken BR must flip it
        next_cycle();
        drive_ex(1'b1, 32'h344, OP_BRANCH, 1'b1, 32'h800, 1'b0, 32'h348);
        check_res("post_rst_br", 1'b1, 2'b01, 32'h800);

        next_cycle();
        drive_ex(1'b0, 32'h0, OP_ALU, 1'b0, 32'h0, 1'b0, 32'h0);
        check_pred("post_rst_br_pred", 32'h344, 1'b1, 32'h800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Parametrised successor to the pipeline's EX-stage branch control; it adds dynamic prediction.
- Holds a bimodal branch history table (BHT) of saturating counters and a direct-mapped branch target buffer (BTB).
- IF stage: predicts direction and target for the fetch PC.
- EX stage: resolves branch/JAL/JALR outcomes, trains the tables, and raises a redirect/flush on misprediction.

Parameters:
- XLEN, 32, address/data width.
- BHT_ENTRIES, 64, number of counters; power of 2, ≥2.
- BTB_ENTRIES, 16, number of BTB entries; power of 2, ≥2.
- CNT_W, 2, counter width in bits; ≥2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- if_pc  in  XLEN  fetch PC.
- pred_taken  out  1  IF prediction: taken.
- pred_target  out  XLEN  IF predicted next PC (target if taken, else if_pc+4).
- ex_valid  in  1  EX holds a valid instruction.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_opcode  in  7  opcode of the EX instruction.
- ex_cond  in  1  branch condition met (from the ALU compare).
- ex_target  in  XLEN  computed target (branch/JAL/JALR).
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_target  in  XLEN  predicted next PC carried down the pipe.
- redirect  out  1  misprediction; flush IF/ID and load redirect_pc.
- redirect_pc  out  XLEN  correct next PC.
- pc_sel  out  2  00 = use pred_target, 01 = redirect to target, 10 = redirect to ex_pc+4.

Behaviour:
- Classification: BR = 1100011, JAL = 1101111, JALR = 1100111. Any other opcode, or ex_valid=0, is non-control: no update, redirect=0, pc_sel=00.
- Indexing:
  - BHT index = pc[log2(BHT_ENTRIES)+1:2].
  - BTB index = pc[log2(BTB_ENTRIES)+1:2].
  - BTB tag = pc[XLEN-1:log2(BTB_ENTRIES)+2].
- Prediction (combinational, zero latency, from registered state):
  - btb_hit = valid & tag match.
  - BTB entry holds: target, is_jump bit.
  - pred_taken = btb_hit & (is_jump | counter MSB).
  - pred_target = pred_taken ? btb_target : if_pc+4, with XLEN wrap on +4.
- Resolution (combinational from EX inputs):
  - actual_taken = JAL | JALR | (BR & ex_cond).
  - actual_next = actual_taken ? ex_target : ex_pc+4.
  - redirect = valid control op & (actual_taken≠ex_pred_taken | (actual_taken & ex_target≠ex_pred_target)).
  - pc_sel = 01 if redirect & actual_taken; 10 if redirect & !actual_taken; else 00.
  - redirect_pc = actual_next.
- Training (posedge, ex_valid & control op):
  - BR: counter[ex_pc] +1 if taken, −1 if not; saturate at 0 and 2^CNT_W−1.
  - JAL/JALR: counter untouched.
  - Taken op: BTB entry written (valid=1, tag, target=ex_target, is_jump = JAL|JALR); an existing entry is overwritten.
  - Not-taken BR with BTB hit: entry kept (counter decides).
- Same-cycle read/write of one index: the IF read returns the pre-update value; the new value is visible next cycle.
- Reset (rst=0 at posedge):
  - All counters = weakly-not-taken (2^(CNT_W−1)−1, i.e. 01 for CNT_W=2).
  - All BTB valid bits = 0.
  - Stats counters = 0.
  - Reset wins over a simultaneous update.
- Outputs under reset: combinational outputs still follow inputs. After reset, pred_taken=0 and pred_target=if_pc+4.

Optional Feature:
- Macro: BPU_STATS_EN.
- When defined:
  - Adds outputs stat_branches [31:0] and stat_mispredicts [31:0].
  - stat_branches increments on every resolved control op; stat_mispredicts increments when redirect=1.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- When undefined: ports and registers absent; behaviour otherwise identical.

Decomposition:
- Shared package (bpu_pkg):
  - Opcode constants OP_BRANCH, OP_JAL, OP_JALR.
  - pc_sel encodings PCSEL_PRED/PCSEL_TARGET/PCSEL_SEQ.
  - Counter reset-value function.
- One sub-module: sat_counter (CNT_W-wide, inc/dec/hold with saturation), instantiated per BHT entry or used as an update function.

Test Plan:
- Reset then if_pc=0x100 → pred_taken=0, pred_target=0x104; no redirect for a non-control EX op.
- BR at 0x200, ex_cond=1, target 0x180, ex_pred_taken=0 → redirect=1, pc_sel=01, redirect_pc=0x180; next cycle if_pc=0x200 → pred_taken=1, pred_target=0x180.
- Same BR taken 3 more times → counter saturates at 3; then 2 not-taken (ex_cond=0) → first gives redirect=1, pc_sel=10, redirect_pc=0x204; counter reaches 1 and the prediction flips to not-taken.
- JAL at 0x300 → 0x400 → BTB is_jump set; later prediction taken regardless of counter; correct ex_pred_target=0x400 → redirect=0.
- JALR predicted taken to 0x500 but ex_target=0x600 → redirect=1, pc_sel=01, redirect_pc=0x600; BTB target updated.
- rst=0 asserted mid-training with ex_valid=1 → all tables cleared, prior BTB hit lost; with BPU_STATS_EN, both stats read 0.
